// File: rtl/zoom_out_block_average_if.sv
// Source-ROM / frame-RAM bus of the 2x zoom-out engine, plus its start/status handshake.
// slave is the engine side; master is the frame controller / memory side.
interface zoom_out_block_average_if;
  logic        start;
  logic [15:0] img_width;
  logic [15:0] img_height;
  logic [7:0]  rom_data_in;
  logic [16:0] rom_addr;
  logic [18:0] ram_addr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic        busy;
  logic        done;

  modport slave (
    input  start, img_width, img_height, rom_data_in,
    output rom_addr, ram_addr, ram_data, ram_wren, busy, done
  );

  modport master (
    output start, img_width, img_height, rom_data_in,
    input  rom_addr, ram_addr, ram_data, ram_wren, busy, done
  );
endinterface

// File: rtl/zoom_out_block_average.sv
// 2x zoom-out: each output pixel is the rounded mean of a 2x2 source block read from ROM.
// One output pixel every ROM_LATENCY+5 cycles; start is ignored while busy.
module zoom_out_block_average #(
  parameter int ROM_LATENCY = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  zoom_out_block_average_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, ADDR, COLLECT, WRITE, DONE} state_t;

  state_t state, state_nxt;

  logic [15:0] width_q;
  logic [15:0] ow_q, oh_q;
  logic [15:0] ox, oy;
  logic        empty_q;
  logic [16:0] top_base, bot_base, col_off;
  logic [1:0]  phase;
  logic [ROM_LATENCY-1:0] smp_pipe;
  logic [9:0]  acc;
  logic [1:0]  smp_cnt;
  logic        acc_full;

  logic [16:0] rom_addr_q;
  logic [18:0] ram_addr_q;
  logic [7:0]  ram_data_q;
  logic        ram_wren_q, busy_q, done_q;

  logic        accept, issue, row_end, last_blk, start_empty;
  logic [16:0] issue_addr, tl_addr, bl_addr, width_ext;
  logic [9:0]  rounded;

  assign tl_addr     = top_base + col_off;
  assign bl_addr     = bot_base + col_off;
  assign width_ext   = {1'b0, width_q};
  assign row_end     = (ox == ow_q - 16'd1);
  assign last_blk    = row_end && (oy == oh_q - 16'd1);
  assign start_empty = ((bus.img_width >> 1) == 16'd0) || ((bus.img_height >> 1) == 16'd0);
  assign rounded     = acc + 10'd2;

  assign bus.rom_addr = rom_addr_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_data = ram_data_q;
  assign bus.ram_wren = ram_wren_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // issue/issue_addr: a new ROM address is registered on this edge
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    issue      = 1'b0;
    issue_addr = '0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = ADDR;
          if (!start_empty) begin
            issue      = 1'b1;
            issue_addr = '0;
          end
        end
      end
      ADDR: begin
        if (empty_q) begin
          state_nxt = DONE;
        end else begin
          case (phase)
            2'd0:    begin issue = 1'b1; issue_addr = tl_addr + 17'd1; end
            2'd1:    begin issue = 1'b1; issue_addr = bl_addr;         end
            2'd2:    begin issue = 1'b1; issue_addr = bl_addr + 17'd1; end
            default: state_nxt = COLLECT;
          endcase
        end
      end
      COLLECT: begin
        if (acc_full) state_nxt = WRITE;
      end
      WRITE: begin
        if (last_blk) begin
          state_nxt = DONE;
        end else begin
          state_nxt  = ADDR;
          issue      = 1'b1;
          issue_addr = row_end ? (bot_base + width_ext) : (tl_addr + 17'd2);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      width_q    <= '0;
      ow_q       <= '0;
      oh_q       <= '0;
      ox         <= '0;
      oy         <= '0;
      empty_q    <= 1'b0;
      top_base   <= '0;
      bot_base   <= '0;
      col_off    <= '0;
      phase      <= '0;
      smp_pipe   <= '0;
      acc        <= '0;
      smp_cnt    <= '0;
      acc_full   <= 1'b0;
      rom_addr_q <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wren_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (issue) rom_addr_q <= issue_addr;

      // Tag each issued address so its data is captured exactly ROM_LATENCY edges later
      smp_pipe[0] <= issue;
      for (int i = 1; i < ROM_LATENCY; i++) smp_pipe[i] <= smp_pipe[i-1];
      if (smp_pipe[ROM_LATENCY-1]) begin
        acc     <= acc + {2'b00, bus.rom_data_in};
        smp_cnt <= smp_cnt + 2'd1;
        if (smp_cnt == 2'd3) acc_full <= 1'b1;
      end

      ram_wren_q <= (state == COLLECT) && acc_full;

      case (state)
        IDLE, DONE: begin
          if (accept) begin
            width_q    <= bus.img_width;
            ow_q       <= bus.img_width >> 1;
            oh_q       <= bus.img_height >> 1;
            empty_q    <= start_empty;
            ox         <= '0;
            oy         <= '0;
            top_base   <= '0;
            bot_base   <= {1'b0, bus.img_width};
            col_off    <= '0;
            phase      <= '0;
            acc        <= '0;
            smp_cnt    <= '0;
            acc_full   <= 1'b0;
            ram_addr_q <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        ADDR: begin
          if (empty_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            phase <= phase + 2'd1;
          end
        end
        COLLECT: begin
          if (acc_full) begin
            ram_data_q <= rounded[9:2];
            acc        <= '0;
            acc_full   <= 1'b0;
          end
        end
        WRITE: begin
          ram_addr_q <= ram_addr_q + 19'd1;
          if (last_blk) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (row_end) begin
            ox       <= '0;
            col_off  <= '0;
            oy       <= oy + 16'd1;
            top_base <= top_base + width_ext + width_ext;
            bot_base <= bot_base + width_ext + width_ext;
          end else begin
            ox      <= ox + 16'd1;
            col_off <= col_off + 17'd2;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/zoom_out_block_average.md
Name: zoom_out_block_average

Overview:
Produces a 2x zoom-out of an 8-bit grayscale image. Each output pixel is the rounded mean of a 2x2 block of the source image.
- Reads the source frame from the image ROM (row-major, one byte per pixel).
- Writes the half-size frame, row-major and packed, into the frame RAM.
- Sits on the same ROM/RAM pair as the zoom-in replicator and is the inverse operation. The control logic selects one or the other per frame.

Parameters:
ROM_LATENCY, 1, number of clock edges between a rom_addr value being registered and the corresponding rom_data_in being sampled (legal 1..3)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  single-cycle request; accepted only in IDLE or DONE
img_width  input  16  source width in pixels; sampled when start is accepted
img_height  input  16  source height in pixels; sampled when start is accepted
rom_data_in  input  8  pixel returned by ROM
rom_addr  output  17  ROM read address (registered)
ram_addr  output  19  RAM write address (registered)
ram_data  output  8  RAM write data (registered)
ram_wren  output  1  RAM write enable, one-cycle strobe per output pixel
busy  output  1  high from accepted start until done rises
done  output  1  level; high after the frame completes, cleared by the next accepted start or by reset

Behaviour:
- Clock and reset: reset is synchronous and active-high on clock. Reset returns the FSM to IDLE and clears all outputs and internal counters to 0 (rom_addr, ram_addr, ram_data, ram_wren, busy, done).
- Reset mid-frame: abort immediately. No further ram_wren; no partial write completes.
- Output geometry: OW = img_width>>1, OH = img_height>>1. An odd last column or row is dropped and never read.
- Output value: out(ox,oy) = (p(2ox,2oy) + p(2ox+1,2oy) + p(2ox,2oy+1) + p(2ox+1,2oy+1) + 2) >> 2.
  - Accumulator is 10 bits; the result always fits in 8 bits, so no saturation is needed.
- Addressing:
  - Source address = y*img_width + x. It is kept incrementally with row-base registers (top row base, bottom row base = top + img_width). No multiplier or divider.
  - After each block: column offset += 2. At the end of an output row: top base += 2*img_width.
  - ram_addr = oy*OW + ox, a plain counter starting at 0 and incrementing after each write.
- FSM states: IDLE, ADDR, COLLECT, WRITE, DONE.
  - IDLE/DONE: on start, latch the dimensions, clear done, set busy.
    - If OW==0 or OH==0: go to DONE the next cycle with zero writes (busy high for exactly 1 cycle).
    - Otherwise go to ADDR.
  - ADDR: 4 consecutive cycles. rom_addr takes TL, TR, BL, BR of the current block, one per cycle.
  - COLLECT: accumulate each rom_data_in arriving ROM_LATENCY edges after its address. Leave when the 4th sample (BR) has been added.
  - WRITE: exactly one cycle with ram_wren=1, ram_data=rounded mean, ram_addr=current output index.
    - The next cycle ram_wren=0 and ram_addr has incremented.
    - Then ADDR for the next block, or DONE after the last block.
  - DONE: busy=0, done=1, ram_wren=0. rom_addr/ram_addr hold their last values.
- Timing:
  - Per output pixel, from the first TL address cycle to the next TL address cycle = ROM_LATENCY+5 cycles.
  - The first TL address is registered on the edge that accepts start.
  - done rises on the edge after the last WRITE cycle.
- start while busy is ignored; dimension changes while busy are ignored.
- ram_wren is never high outside WRITE. Exactly OW*OH write strobes occur per frame.

Test Plan:
1. ROM_LATENCY=1, 4x4 image with p[i]=i, start pulse -> 4 writes.
   - Addresses 0,1,2,3; data 3,5,11,13.
   - First block reads rom_addr 0,1,4,5.
   - done high one cycle after the 4th write; busy low.
2. Rounding: 2x2 blocks {255,255,255,255} -> 255; {0,0,0,1} -> 0; {0,0,1,1} -> 1; {0,1,1,1} -> 1; {1,1,1,2} -> 1 (5+2=7>>2=1).
3. Odd dims 5x3 -> exactly 2 writes (addr 0,1). rom_addr never takes values 4, 9, or 10..14.
4. Degenerate dims 1x8 and 8x1 -> zero ram_wren strobes; busy high exactly 1 cycle, then done.
5. 8x4 frame:
   - Assert reset 1 cycle after the 2nd write -> all outputs 0 next cycle, no further writes.
   - A new start then completes all 8 writes with addresses 0..7.
6. ROM_LATENCY=2, 4x2 image:
   - 2 writes whose ram_wren strobes are exactly 7 cycles apart.
   - A start pulse while busy has no effect; a second start after done reruns the frame and clears done on acceptance.
